// File: rtl/shift_cmd_feeder_pkg.sv
// Shared types for the shift command feeder: default widths, command struct, slot state.
package shift_pkg;
   localparam int DEF_DATA_W  = 4;
   localparam int DEF_SHAMT_W = 2;
   localparam int DEF_DEPTH   = 2;

   typedef struct packed {
      logic [DEF_DATA_W-1:0]  x;
      logic [DEF_SHAMT_W-1:0] shamt;
   } shift_cmd_t;

   typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
endpackage

// File: rtl/shift_cmd_feeder_if.sv
// Command/result bus of the feeder; slave = feeder, master = producer/shifter/consumer side.
// SHIFT_CMD_FEEDER_OVF_EN adds out_ovf.
interface shift_cmd_feeder_if #(
   parameter int DATA_W  = 4,
   parameter int SHAMT_W = 2,
   parameter int DEPTH   = 2
) ();
   localparam int CW = $clog2(DEPTH) + 1;

   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  in_x;
   logic [SHAMT_W-1:0] in_shift;
   logic [DATA_W-1:0]  x;
   logic [SHAMT_W-1:0] shift;
   logic [DATA_W-1:0]  s;
   logic               out_valid;
   logic               out_ready;
   logic [DATA_W-1:0]  out_s;
   logic [CW-1:0]      count;
`ifdef SHIFT_CMD_FEEDER_OVF_EN
   logic               out_ovf;

   modport slave  (input  in_valid, in_x, in_shift, s, out_ready,
                   output in_ready, x, shift, out_valid, out_s, count, out_ovf);
   modport master (output in_valid, in_x, in_shift, s, out_ready,
                   input  in_ready, x, shift, out_valid, out_s, count, out_ovf);
`else
   modport slave  (input  in_valid, in_x, in_shift, s, out_ready,
                   output in_ready, x, shift, out_valid, out_s, count);
   modport master (output in_valid, in_x, in_shift, s, out_ready,
                   input  in_ready, x, shift, out_valid, out_s, count);
`endif
endinterface

// File: rtl/shift_cmd_fifo.sv
// DEPTH-entry circular command buffer with exact occupancy count.
module shift_cmd_fifo
   import shift_pkg::*;
#(
   parameter int  DEPTH = DEF_DEPTH,
   parameter type T     = shift_cmd_t,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  T              wr_data,
   output T              rd_data,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   T             mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   // DEPTH is a power of two, so pointer increments wrap naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/shift_cmd_feeder.sv
// Feeds buffered {x, shamt} commands to an external shifter and registers its result.
// SHIFT_CMD_FEEDER_OVF_EN adds the shifted-out-ones flag out_ovf.
module shift_cmd_feeder
   import shift_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int SHAMT_W = DEF_SHAMT_W,
   parameter int DEPTH   = DEF_DEPTH
) (
   input logic              clk,
   input logic              rst,
   shift_cmd_feeder_if.slave bus
);
   typedef struct packed {
      logic [DATA_W-1:0]  x;
      logic [SHAMT_W-1:0] shamt;
   } cmd_t;

   cmd_t        wr_cmd, head;
   logic        full, empty, pop;
   slot_state_t state_q, state_d;

   assign wr_cmd.x     = bus.in_x;
   assign wr_cmd.shamt = bus.in_shift;

   shift_cmd_fifo #(.DEPTH(DEPTH), .T(cmd_t)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (bus.in_valid),
      .pop     (pop),
      .wr_data (wr_cmd),
      .rd_data (head),
      .count   (bus.count),
      .full    (full),
      .empty   (empty)
   );

   // Ready depends on registered occupancy only, never on this cycle's pop
   assign bus.in_ready  = rst | ~full;
   assign bus.x         = empty ? '0 : head.x;
   assign bus.shift     = empty ? '0 : head.shamt;
   assign bus.out_valid = (state_q == SLOT_FULL);

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         SLOT_EMPTY: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = SLOT_FULL;
            end
         end
         SLOT_FULL: begin
            if (bus.out_ready) begin
               if (!empty) pop = 1'b1;
               else        state_d = SLOT_EMPTY;
            end
         end
         default: state_d = SLOT_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= SLOT_EMPTY;
         bus.out_s <= '0;
      end else begin
         state_q <= state_d;
         if (pop) bus.out_s <= bus.s;
      end
   end

`ifdef SHIFT_CMD_FEEDER_OVF_EN
   logic [DATA_W-1:0] lost;
   logic              ovf;

   // Bits of x that the shifter drops off the top
   assign lost = bus.x >> (DATA_W - int'(bus.shift));
   assign ovf  = (bus.shift != '0) && (lost != '0);

   always_ff @(posedge clk) begin
      if (rst)      bus.out_ovf <= 1'b0;
      else if (pop) bus.out_ovf <= ovf;
   end
`endif
endmodule

// File: tb/tb_shift_cmd_feeder.sv
// Directed bench for shift_cmd_feeder with a behavioural shifter (S = X << SHIFT).
module tb_shift_cmd_feeder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   failed = 0;

   shift_cmd_feeder_if #(.DATA_W(4), .SHAMT_W(2), .DEPTH(2)) bus ();

   shift_cmd_feeder #(.DATA_W(4), .SHAMT_W(2), .DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.s = bus.x << bus.shift;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] xv, input logic [1:0] sv);
      bus.in_valid = v;
      bus.in_x     = xv;
      bus.in_shift = sv;
   endtask

   logic [3:0] t4_x   [9] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h9, 4'h5, 4'hA, 4'h6, 4'hE};
   logic [1:0] t4_sh  [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1};
   logic [3:0] t4_exp [9] = '{4'h1, 4'h6, 4'hC, 4'h8, 4'h2, 4'h4, 4'hA, 4'h0, 4'hC};

   initial begin
      drive(1'b0, 4'h0, 2'd0);
      bus.out_ready = 1'b0;
      step();
      step();
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_s", 32'(bus.out_s), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 1);
      rst = 1'b0;

      // 1: single command, latency
      drive(1'b1, 4'b0011, 2'd2);
      bus.out_ready = 1'b1;
      step();
      chk("t1_count", 32'(bus.count), 1);
      chk("t1_valid_n", 32'(bus.out_valid), 0);
      chk("t1_x", 32'(bus.x), 4'b0011);
      chk("t1_shift", 32'(bus.shift), 2);
      drive(1'b0, 4'h0, 2'd0);
      step();
      chk("t1_valid_n1", 32'(bus.out_valid), 1);
      chk("t1_out_s", 32'(bus.out_s), 4'b1100);
      chk("t1_count0", 32'(bus.count), 0);
      step();
      chk("t1_drain", 32'(bus.out_valid), 0);

      // 2: back-to-back with stalled consumer
      bus.out_ready = 1'b0;
      drive(1'b1, 4'h1, 2'd1);
      step();
      chk("t2_c1", 32'(bus.count), 1);
      drive(1'b1, 4'h2, 2'd1);
      step();
      chk("t2_c2", 32'(bus.count), 1);
      chk("t2_slot_a", 32'(bus.out_s), 4'h2);
      drive(1'b1, 4'h3, 2'd0);
      step();
      chk("t2_full_count", 32'(bus.count), 2);
      chk("t2_in_ready", 32'(bus.in_ready), 0);
      chk("t2_hold_a", 32'(bus.out_s), 4'h2);
      drive(1'b0, 4'h0, 2'd0);
      bus.out_ready = 1'b1;
      step();
      chk("t2_res_b", 32'(bus.out_s), 4'h4);
      chk("t2_ready_back", 32'(bus.in_ready), 1);
      step();
      chk("t2_res_c", 32'(bus.out_s), 4'h3);
      chk("t2_res_c_v", 32'(bus.out_valid), 1);
      step();
      chk("t2_drain", 32'(bus.out_valid), 0);

      // 3: stall holds result and head
      bus.out_ready = 1'b0;
      drive(1'b1, 4'b1011, 2'd1);
      step();
      drive(1'b1, 4'b0101, 2'd2);
      step();
      drive(1'b0, 4'h0, 2'd0);
      for (int i = 0; i < 5; i++) begin
         chk("t3_out_s", 32'(bus.out_s), 4'b0110);
         chk("t3_x", 32'(bus.x), 4'b0101);
         chk("t3_shift", 32'(bus.shift), 2);
         chk("t3_count", 32'(bus.count), 1);
         step();
      end
      bus.out_ready = 1'b1;
      step();
      chk("t3_next", 32'(bus.out_s), 4'b0100);
      step();
      chk("t3_drain", 32'(bus.out_valid), 0);

      // 4: simultaneous push/pop at count 1, pointers wrap
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, t4_x[i], t4_sh[i]);
         step();
         chk("t4_count", 32'(bus.count), 1);
         if (i > 0) chk("t4_out_s", 32'(bus.out_s), 32'(t4_exp[i-1]));
      end
      drive(1'b0, 4'h0, 2'd0);
      step();
      chk("t4_last", 32'(bus.out_s), 32'(t4_exp[8]));
      chk("t4_count0", 32'(bus.count), 0);
      step();

      // 5: reset mid-stream
      bus.out_ready = 1'b0;
      drive(1'b1, 4'h1, 2'd1);
      step();
      drive(1'b1, 4'h2, 2'd1);
      step();
      drive(1'b1, 4'h3, 2'd1);
      step();
      chk("t5_pre_count", 32'(bus.count), 2);
      chk("t5_pre_valid", 32'(bus.out_valid), 1);
      rst = 1'b1;
      #1;
      chk("t5_rst_in_ready", 32'(bus.in_ready), 1);
      step();
      chk("t5_count", 32'(bus.count), 0);
      chk("t5_valid", 32'(bus.out_valid), 0);
      chk("t5_out_s", 32'(bus.out_s), 0);
      chk("t5_x", 32'(bus.x), 0);
      chk("t5_shift", 32'(bus.shift), 0);
`ifdef SHIFT_CMD_FEEDER_OVF_EN
      chk("t5_ovf", 32'(bus.out_ovf), 0);
`endif
      rst = 1'b0;
      drive(1'b0, 4'h0, 2'd0);
      step();
      chk("t5_ignored", 32'(bus.count), 0);

`ifdef SHIFT_CMD_FEEDER_OVF_EN
      // 6: overflow flag
      bus.out_ready = 1'b1;
      drive(1'b1, 4'b1001, 2'd3);
      step();
      drive(1'b1, 4'b0001, 2'd3);
      step();
      chk("t6_s_a", 32'(bus.out_s), 4'b1000);
      chk("t6_ovf_a", 32'(bus.out_ovf), 1);
      drive(1'b0, 4'h0, 2'd0);
      step();
      chk("t6_s_b", 32'(bus.out_s), 4'b1000);
      chk("t6_ovf_b", 32'(bus.out_ovf), 0);
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
